cap_bank_sequencer: RTL and testbench
=====================================

# cap_bank_sequencer

Sequences updates of the series and parallel capacitor-bank codes in the QCM master controller. It takes code requests that the frequency-measurement/lookup path emits after each measurement window. It filters the requests for noise by requiring repeated identical requests, then applies them with a break-before-make protocol: enables low, settle, new codes, settle, enables high. A measurement watchdog forces both banks to a safe disabled state when the RF signal is lost.

## Interface
- `CODE_W`, 7, width of each capacitor code
- `SETTLE_CYC`, 40, clk cycles spent in each of the break and load dwells (≥1)
- `CONFIRM`, 2, consecutive identical requests needed to accept one (≥1)
- `TIMEOUT_CYC`, 200000, clk cycles without `measValid` before fault (≥2)

- `clk`  in  1  system clock; all logic on posedge
- `resetN`  in  1  asynchronous, active-low reset
- `measValid`  in  1  one-cycle pulse: new measurement, request codes valid
- `codeSerReq`  in  CODE_W  requested series-bank code
- `codeParReq`  in  CODE_W  requested parallel-bank code
- `codeSer`  out  CODE_W  applied series-bank code
- `codePar`  out  CODE_W  applied parallel-bank code
- `enableSer`  out  1  series-bank enable
- `enablePar`  out  1  parallel-bank enable
- `busy`  out  1  high in BREAK or LOAD
- `fault`  out  1  watchdog timeout latched

## Operation
- States: SAFE, RUN, BREAK, LOAD. Reset puts the block in SAFE with all outputs 0: codes 0, enables 0, busy 0, fault 0.
- Confirmation filter:
  - On `measValid`, the pair {ser, par} is compared with the last sampled pair.
  - If the pair is equal, `confCnt` increments and saturates at CONFIRM. If it differs, `confCnt` becomes 1.
  - A request is accepted on the cycle `confCnt` reaches CONFIRM. It is accepted again on every further equal sample.
- Handling of an accepted request, by state:
  - SAFE: latch the target, go to BREAK.
  - RUN: if the target differs from the applied codes, latch it and go to BREAK. Otherwise do nothing; the enables do not glitch.
  - BREAK: overwrite the target. The dwell timer does not restart.
  - LOAD: store the request in `pending`, latest wins.
- BREAK: `enableSer`/`enablePar` are 0 for SETTLE_CYC cycles, then go to LOAD.
- LOAD: `codeSer`/`codePar` take the target on entry. After SETTLE_CYC cycles, enables go to 1 and the state goes to RUN.
- RUN with a valid `pending` that differs from the applied codes: go to BREAK on the next edge and clear `pending`. If `pending` equals the applied codes, just clear it.
- Watchdog:
  - The counter clears on every `measValid` and increments otherwise.
  - When it reaches TIMEOUT_CYC, on the next edge: state SAFE, enables 0, `fault` 1, `pending` cleared.
  - Codes hold their last values. This aborts BREAK/LOAD.
- `fault` clears on the next accepted request.
- Simultaneous `measValid` and watchdog terminal count: `measValid` wins and no fault is raised.

## Timing
- Let edge t be the edge that samples the confirming `measValid`, with the request accepted from RUN or SAFE.
  - t+1: BREAK, enables 0, busy 1.
  - t+1+SETTLE_CYC: LOAD, codes updated.
  - t+1+2·SETTLE_CYC: RUN, enables 1, busy 0.
- Total latency from acceptance to enable is 1+2·SETTLE_CYC cycles.
- Fault assertion occurs on the edge after the watchdog reaches TIMEOUT_CYC.
- Reset assertion clears everything immediately, independent of `clk`. Deassertion is synchronized externally.
- Counter widths: $clog2(max+1) for each.

## Structure
- Package `qcm_mc_pkg`: CODE_W default, state enum `seq_state_t` {SAFE, RUN, BREAK, LOAD}.
- Sub-module `meas_watchdog`: parameter TIMEOUT_CYC; inputs `clk`, `resetN`, `kick`; output `expired` (one-cycle pulse, then re-arms).
- The dwell timer and confirmation filter are inline.

## Test plan
Parameters for all cases: SETTLE_CYC=4, CONFIRM=2, TIMEOUT_CYC=100.
1. Reset pulse → all outputs 0, busy 0, fault 0.
2. `measValid` with (10,20) at cycles 5 and 7 → edge 8: enables 0, busy 1; edge 12: codes 10/20; edge 16: enables 1, busy 0.
3. Alternating (10,20),(11,20) ×6 → no acceptance; outputs unchanged.
4. In RUN at (10,20), feed (10,20) ×4 → enables stay 1 every cycle, busy 0.
5. No `measValid` for 100 cycles in RUN → enables 0, fault 1, codes held at 10/20. Then (30,40) ×2 → fault 0 at acceptance, full sequence, ends RUN at 30/40.
6. Confirmed (5,6) arriving during LOAD → after RUN, exactly one more BREAK/LOAD, ends at 5/6. Separate run: `resetN` low mid-LOAD → all outputs 0 immediately.

Source files
------------

// File: rtl/qcm_mc_pkg.sv
// Shared types for the QCM master controller: default code width and the
// capacitor-bank sequencer state encoding.
package qcm_mc_pkg;
  localparam int CODE_W_DEF = 7;

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2,
    LOAD  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/meas_watchdog.sv
// Measurement watchdog: counts cycles since the last kick and emits a one-cycle
// expired pulse at TIMEOUT_CYC, then re-arms. A kick in that cycle suppresses it.
module meas_watchdog #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk,
  input  logic resetN,
  input  logic kick,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = !kick && (cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              cnt <= '0;
    else if (kick || expired) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cap_bank_sequencer.sv
// Capacitor-bank code sequencer: confirms repeated code requests, applies them
// break-before-make (enables off, settle, load codes, settle, enables on).
module cap_bank_sequencer
  import qcm_mc_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int SETTLE_CYC  = 40,
  parameter int CONFIRM     = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              measValid,
  input  logic [CODE_W-1:0] codeSerReq,
  input  logic [CODE_W-1:0] codeParReq,
  output logic [CODE_W-1:0] codeSer,
  output logic [CODE_W-1:0] codePar,
  output logic              enableSer,
  output logic              enablePar,
  output logic              busy,
  output logic              fault
);
  localparam int PAIR_W  = 2 * CODE_W;
  localparam int CONF_W  = $clog2(CONFIRM + 1);
  localparam int DWELL_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CONF_W-1:0]  CONF_MAX = CONF_W'(CONFIRM);
  localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(SETTLE_CYC - 1);

  seq_state_t         state, state_nxt;
  logic [PAIR_W-1:0]  req_pair, last_pair;
  logic [CONF_W-1:0]  conf_cnt, conf_nxt;
  logic               acc, acc_q;
  logic [PAIR_W-1:0]  applied, applied_nxt;
  logic [PAIR_W-1:0]  target, target_nxt;
  logic [PAIR_W-1:0]  pend, pend_nxt;
  logic               pend_vld, pend_vld_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic               dwell_done;
  logic               en_q, en_nxt;
  logic               fault_q, fault_nxt;
  logic               expired;

  meas_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .resetN  (resetN),
    .kick    (measValid),
    .expired (expired)
  );

  // Confirmation filter; conf_cnt == 0 means no sample seen since reset.
  assign req_pair = {codeSerReq, codeParReq};

  always_comb begin
    conf_nxt = CONF_W'(1);
    if (conf_cnt != '0 && req_pair == last_pair)
      conf_nxt = (conf_cnt == CONF_MAX) ? CONF_MAX : conf_cnt + 1'b1;
    acc = measValid && (conf_nxt == CONF_MAX);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      conf_cnt  <= '0;
      last_pair <= '0;
      acc_q     <= 1'b0;
    end else begin
      acc_q <= acc;
      if (measValid) begin
        conf_cnt  <= conf_nxt;
        last_pair <= req_pair;
      end
    end
  end

  // While acc_q is high, last_pair still holds the accepted request.
  assign dwell_done = (dwell == DWELL_END);

  always_comb begin
    state_nxt    = state;
    applied_nxt  = applied;
    target_nxt   = target;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    dwell_nxt    = dwell;
    en_nxt       = en_q;
    fault_nxt    = fault_q;
    if (expired) begin
      state_nxt    = SAFE;
      en_nxt       = 1'b0;
      fault_nxt    = 1'b1;
      pend_vld_nxt = 1'b0;
      dwell_nxt    = '0;
    end else begin
      if (acc_q) fault_nxt = 1'b0;
      case (state)
        SAFE: if (acc_q) begin
          target_nxt = last_pair;
          state_nxt  = BREAK;
          dwell_nxt  = '0;
          en_nxt     = 1'b0;
        end
        RUN: begin
          if (acc_q) begin
            pend_vld_nxt = 1'b0;
            if (last_pair != applied) begin
              target_nxt = last_pair;
              state_nxt  = BREAK;
              dwell_nxt  = '0;
              en_nxt     = 1'b0;
            end
          end else if (pend_vld) begin
            pend_vld_nxt = 1'b0;
            if (pend != applied) begin
              target_nxt = pend;
              state_nxt  = BREAK;
              dwell_nxt  = '0;
              en_nxt     = 1'b0;
            end
          end
        end
        BREAK: begin
          if (acc_q) target_nxt = last_pair;
          dwell_nxt = dwell + 1'b1;
          if (dwell_done) begin
            state_nxt   = LOAD;
            dwell_nxt   = '0;
            applied_nxt = target_nxt;
          end
        end
        LOAD: begin
          if (acc_q) begin
            pend_nxt     = last_pair;
            pend_vld_nxt = 1'b1;
          end
          dwell_nxt = dwell + 1'b1;
          if (dwell_done) begin
            state_nxt = RUN;
            dwell_nxt = '0;
            en_nxt    = 1'b1;
          end
        end
        default: state_nxt = SAFE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= SAFE;
      applied  <= '0;
      target   <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      dwell    <= '0;
      en_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      applied  <= applied_nxt;
      target   <= target_nxt;
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
      dwell    <= dwell_nxt;
      en_q     <= en_nxt;
      fault_q  <= fault_nxt;
    end
  end

  assign codeSer   = applied[PAIR_W-1:CODE_W];
  assign codePar   = applied[CODE_W-1:0];
  assign enableSer = en_q;
  assign enablePar = en_q;
  assign busy      = (state == BREAK) || (state == LOAD);
  assign fault     = fault_q;
endmodule

// File: tb/tb_cap_bank_sequencer.sv
// Bench for cap_bank_sequencer: directed scenarios plus random traffic, all
// compared every cycle against a timestamp-based reference model.
module tb_cap_bank_sequencer;
  localparam int CW = 7, SETTLE = 4, CONF = 2, TMO = 100;

  logic          clk = 1'b0;
  logic          resetN, measValid;
  logic [CW-1:0] codeSerReq, codeParReq, codeSer, codePar;
  logic          enableSer, enablePar, busy, fault;

  cap_bank_sequencer #(
    .CODE_W(CW), .SETTLE_CYC(SETTLE), .CONFIRM(CONF), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .resetN(resetN), .measValid(measValid),
    .codeSerReq(codeSerReq), .codeParReq(codeParReq),
    .codeSer(codeSer), .codePar(codePar),
    .enableSer(enableSer), .enablePar(enablePar),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0, n_bad = 0, n = 0;
  string tag = "init";

  // Reference model: request history, absolute edge times of the dwell phases.
  logic [2*CW-1:0] hist[$];
  logic            acc_prev;
  logic [2*CW-1:0] acc_pair, m_code, m_tgt, m_pend;
  logic            m_en, m_fault, m_pvld, active, safe;
  int              load_e, run_e, wd_ref;

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0h expected %0h", t, n, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({codeSer, codePar, enableSer, enablePar, busy, fault});
  endfunction

  function automatic logic [31:0] mdl_vec();
    return 32'({m_code, m_en, m_en, active, m_fault});
  endfunction

  task automatic model_reset();
    hist.delete();
    acc_prev = 1'b0; acc_pair = '0; m_code = '0; m_tgt = '0; m_pend = '0;
    m_en = 1'b0; m_fault = 1'b0; m_pvld = 1'b0; active = 1'b0; safe = 1'b1;
    load_e = 0; run_e = 0; wd_ref = 0; n = 0;
  endtask

  task automatic start_seq(input logic [2*CW-1:0] p);
    m_tgt = p; active = 1'b1; m_en = 1'b0;
    load_e = n + SETTLE; run_e = n + 2 * SETTLE;
  endtask

  task automatic model_step(input logic mv, input logic [2*CW-1:0] req);
    logic expire, eq;
    n++;
    expire = !mv && (n - wd_ref == TMO + 1);
    if (mv || expire) wd_ref = n;
    if (expire) begin
      active = 1'b0; safe = 1'b1; m_en = 1'b0; m_fault = 1'b1; m_pvld = 1'b0;
    end else begin
      if (acc_prev) m_fault = 1'b0;
      if (!active) begin
        if (acc_prev) begin
          m_pvld = 1'b0;
          if (safe || acc_pair != m_code) start_seq(acc_pair);
        end else if (m_pvld) begin
          m_pvld = 1'b0;
          if (m_pend != m_code) start_seq(m_pend);
        end
      end else if (n <= load_e) begin
        if (acc_prev) m_tgt = acc_pair;
      end else if (acc_prev) begin
        m_pend = acc_pair; m_pvld = 1'b1;
      end
      if (active && n == load_e) m_code = m_tgt;
      if (active && n == run_e) begin m_en = 1'b1; active = 1'b0; safe = 1'b0; end
    end
    acc_prev = 1'b0;
    if (mv) begin
      hist.push_back(req);
      if (hist.size() > CONF) void'(hist.pop_front());
      eq = (hist.size() == CONF);
      foreach (hist[i]) if (hist[i] != req) eq = 1'b0;
      acc_prev = eq;
      acc_pair = req;
    end
  endtask

  task automatic cyc(input logic mv, input logic [CW-1:0] s, input logic [CW-1:0] p);
    measValid = mv; codeSerReq = s; codeParReq = p;
    @(posedge clk);
    model_step(mv, {s, p});
    #1 chk(tag, dut_vec(), mdl_vec());
  endtask

  task automatic do_reset(input string t);
    measValid = 1'b0;
    resetN = 1'b0;
    #1 chk(t, dut_vec(), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    model_reset();
  endtask

  initial begin
    int rises, gap;
    logic pb, mv;
    logic [CW-1:0] rs, rp;
    resetN = 1'b1; measValid = 1'b0; codeSerReq = '0; codeParReq = '0;
    #2 do_reset("rst_init");

    tag = "t2";
    for (int k = 1; k <= 18; k++) begin
      cyc(k == 5 || k == 7, 7'd10, 7'd20);
      if (k == 8)  chk("t2_e8_break", 32'({enableSer, enablePar, busy}), 32'd1);
      if (k == 11) chk("t2_e11_codes_old", 32'({codeSer, codePar}), 32'd0);
      if (k == 12) chk("t2_e12_codes", 32'({codeSer, codePar}), 32'({7'd10, 7'd20}));
      if (k == 15) chk("t2_e15_en_low", 32'({enableSer, enablePar, busy}), 32'd1);
      if (k == 16) chk("t2_e16_run", 32'({enableSer, enablePar, busy}), 32'd6);
    end

    tag = "t3";
    for (int k = 0; k < 12; k++) cyc(1'b1, (k % 2 == 0) ? 7'd11 : 7'd10, 7'd20);
    repeat (3) cyc(1'b0, 7'd0, 7'd0);
    chk("t3_unchanged", dut_vec(), 32'({7'd10, 7'd20, 4'b1100}));

    tag = "t4";
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 7'd10, 7'd20);
      chk("t4_en_steady", 32'({enableSer, enablePar, busy}), 32'd6);
    end

    tag = "t5";
    for (int i = 1; i <= 105; i++) begin
      cyc(1'b0, 7'd0, 7'd0);
      if (i == 100) chk("t5_pre_fault", 32'(fault), 32'd0);
      if (i == 101) chk("t5_fault", dut_vec(), 32'({7'd10, 7'd20, 4'b0001}));
    end
    cyc(1'b1, 7'd30, 7'd40);
    cyc(1'b1, 7'd30, 7'd40);
    cyc(1'b0, 7'd0, 7'd0);
    chk("t5_fault_clr", 32'({busy, fault}), 32'd2);
    repeat (2 * SETTLE + 2) cyc(1'b0, 7'd0, 7'd0);
    chk("t5_recovered", dut_vec(), 32'({7'd30, 7'd40, 4'b1100}));

    tag = "t6";
    rises = 0; pb = busy;
    cyc(1'b1, 7'd1, 7'd2);
    cyc(1'b1, 7'd1, 7'd2);
    for (int k = 0; k < 26; k++) begin
      if (busy && !pb) rises++;
      pb = busy;
      if (k == 4 || k == 5) cyc(1'b1, 7'd5, 7'd6);
      else                  cyc(1'b0, 7'd0, 7'd0);
    end
    chk("t6_break_count", 32'(rises), 32'd2);
    chk("t6_final", dut_vec(), 32'({7'd5, 7'd6, 4'b1100}));

    cyc(1'b1, 7'd7, 7'd8);
    cyc(1'b1, 7'd7, 7'd8);
    repeat (6) cyc(1'b0, 7'd0, 7'd0);
    chk("t6_in_load", 32'({codeSer, codePar, busy}), 32'({7'd7, 7'd8, 1'b1}));
    #2 do_reset("t6_rst_mid_load");

    tag = "rnd";
    gap = 0; rs = 7'd3; rp = 7'd9;
    for (int k = 0; k < 3000; k++) begin
      if (gap > 0) gap--;
      else if ($urandom_range(0, 99) == 0) gap = $urandom_range(95, 110);
      mv = (gap == 0) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rs = 7'($urandom_range(0, 2));
        rp = 7'($urandom_range(60, 61));
      end
      cyc(mv, rs, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
